// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with write-first bypass and a self-clearing
// start-up sequence that zeroes every entry before accepting traffic.
module regfile_bypass #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wen,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_r1en,
    input  logic [AW-1:0]   i_r1addr,
    output logic [XLEN-1:0] o_r1data,
    input  logic            i_r2en,
    input  logic [AW-1:0]   i_r2addr,
    output logic [XLEN-1:0] o_r2data,
    output logic            o_ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t            r_state;
    logic [AW-1:0]     r_clr_cnt;
    logic [XLEN-1:0]   r_mem [NREG];
    logic [XLEN-1:0]   r_r1data;
    logic [XLEN-1:0]   r_r2data;
    logic              r_ready;

    logic              w_wr_ok;
    logic [XLEN-1:0]   w_r1_val;
    logic [XLEN-1:0]   w_r2_val;

    // A write is effective unless it targets the hardwired zero register.
    always_comb begin
        w_wr_ok = 1'b0;
        if ((ZERO_REG == 1) && (i_waddr == '0)) begin
            w_wr_ok = 1'b0;
        end else begin
            w_wr_ok = i_wen;
        end
    end

    // Port-1 read value: zero register first, then same-cycle write bypass.
    always_comb begin
        w_r1_val = r_mem[i_r1addr];
        if ((ZERO_REG == 1) && (i_r1addr == '0)) begin
            w_r1_val = '0;
        end else if (w_wr_ok && (i_waddr == i_r1addr)) begin
            w_r1_val = i_wdata;
        end else begin
            w_r1_val = r_mem[i_r1addr];
        end
    end

    // Port-2 read value, identical rules to port 1.
    always_comb begin
        w_r2_val = r_mem[i_r2addr];
        if ((ZERO_REG == 1) && (i_r2addr == '0)) begin
            w_r2_val = '0;
        end else if (w_wr_ok && (i_waddr == i_r2addr)) begin
            w_r2_val = i_wdata;
        end else begin
            w_r2_val = r_mem[i_r2addr];
        end
    end

    // Array storage; the reset edge itself leaves contents untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_ok) begin
                r_mem[i_waddr] <= i_wdata;
            end
        end
    end

    // Control FSM and registered read outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_r1data  <= '0;
            r_r2data  <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_r1data  <= '0;
                    r_r2data  <= '0;
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_r1en) begin
                        r_r1data <= w_r1_val;
                    end
                    if (i_r2en) begin
                        r_r2data <= w_r2_val;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign o_r1data = r_r1data;
    assign o_r2data = r_r2data;
    assign o_ready  = r_ready;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed and randomized checks of regfile_bypass against a behavioural
// register-file model maintained in the bench.
module tb_regfile_bypass;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_wen = 1'b0;
    logic [4:0]  i_waddr = '0;
    logic [31:0] i_wdata = '0;
    logic        i_r1en = 1'b0;
    logic [4:0]  i_r1addr = '0;
    logic [31:0] o_r1data;
    logic        i_r2en = 1'b0;
    logic [4:0]  i_r2addr = '0;
    logic [31:0] o_r2data;
    logic        o_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [32];
    int          m_edges;
    logic        m_ready;
    logic [31:0] m_r1;
    logic [31:0] m_r2;

    regfile_bypass #(.XLEN(32), .NREG(32), .AW(5), .ZERO_REG(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_r1en(i_r1en), .i_r1addr(i_r1addr), .o_r1data(o_r1data),
        .i_r2en(i_r2en), .i_r2addr(i_r2addr), .o_r2data(o_r2data),
        .o_ready(o_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit wen,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (wen && (wa == a)) return wd;
        return m_mem[a];
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit rst_n, input bit wen, input logic [4:0] wa,
                        input logic [31:0] wd, input bit r1en, input logic [4:0] r1a,
                        input bit r2en, input logic [4:0] r2a);
        i_rst_n = rst_n; i_wen = wen; i_waddr = wa; i_wdata = wd;
        i_r1en = r1en; i_r1addr = r1a; i_r2en = r2en; i_r2addr = r2a;
        if (!rst_n) begin
            m_edges = 0; m_ready = 1'b0; m_r1 = 32'd0; m_r2 = 32'd0;
        end else if (!m_ready) begin
            m_mem[m_edges] = 32'd0;
            m_edges++;
            m_ready = (m_edges == 32);
            m_r1 = 32'd0; m_r2 = 32'd0;
        end else begin
            if (r1en) m_r1 = model_read(r1a, wen, wa, wd);
            if (r2en) m_r2 = model_read(r2a, wen, wa, wd);
            if (wen && (wa != 5'd0)) m_mem[wa] = wd;
        end
        @(posedge i_clk);
        #1;
        chk("model_ready", {31'd0, o_ready}, {31'd0, m_ready});
        chk("model_r1", o_r1data, m_r1);
        chk("model_r2", o_r2data, m_r2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 32'hxxxx_xxxx;
        m_edges = 0; m_ready = 1'b0; m_r1 = 32'd0; m_r2 = 32'd0;

        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 1'b1, 5'd3);
        chk("reset_ready", {31'd0, o_ready}, 32'd0);
        chk("reset_r1", o_r1data, 32'd0);

        // Clear sequence with writes/reads attempted; ready only after the 32nd edge.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 5'(i), $urandom, 1'b1, 5'(i), 1'b1, 5'(31 - i));
            chk("clear_ready", {31'd0, o_ready}, (i == 31) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i < 32; i++) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(32 - i));
            chk("init_zero", o_r1data, 32'd0);
        end

        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        chk("rd_x5", o_r1data, 32'hDEADBEEF);

        step(1'b1, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
        chk("bypass_r1", o_r1data, 32'h12345678);
        chk("bypass_r2", o_r2data, 32'h12345678);

        step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd7);
        chk("x0_bypass", o_r1data, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        chk("x0_read", o_r1data, 32'd0);
        chk("x0_read_r2", o_r2data, 32'd0);

        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        chk("hold_pre", o_r1data, 32'hDEADBEEF);
        step(1'b1, 1'b1, 5'd5, 32'h00000001, 1'b0, 5'd5, 1'b0, 5'd0);
        chk("hold_wr", o_r1data, 32'hDEADBEEF);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 1'b0, 5'd0);
        chk("hold_idle", o_r1data, 32'hDEADBEEF);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);
        chk("hold_reen", o_r1data, 32'h00000001);

        // Reset mid-clear, then a full clear; writes during clear must not stick.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("rst_run_r1", o_r1data, 32'd0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 5'(i + 20), 32'hCAFE0000 + 32'(i), 1'b1, 5'(i), 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 5'(31 - i), 32'hBAD00000 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
            chk("reclear_ready", {31'd0, o_ready}, (i == 31) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(i));
            chk("reclear_zero", o_r2data, 32'd0);
        end

        // Random traffic, addresses biased into a small window for frequent bypass hits.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, a1, a2;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 7));
            step(1'b1, 1'($urandom), wa, $urandom, 1'($urandom), a1, 1'($urandom), a2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
